e203_exu_alu_share_arb: RTL and testbench

- Arbiter/sequencer for the shared EXU ALU datapath (adder, logic unit, comparator, two shared buffer registers).
- Four requesters share it: regular ALU, BJP (branch/jump), AGU, and MULDIV.
- ALU and BJP requests are single-cycle. AGU (AMO/unaligned sequences) and MULDIV (iterative multiply/divide) may take exclusive multi-cycle ownership.
- Generates the one-hot datapath select and per-requester ready, gates the shared-buffer write enables to the owner only, and breaks runaway locks with a watchdog.

---
 rtl/e203_exu_alu_share_arb_pkg.sv | 18 +
 rtl/e203_exu_alu_share_wdog.sv | 35 +++
 rtl/e203_exu_alu_share_arb.sv | 131 +++++++++++++
 tb/tb_e203_exu_alu_share_arb.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/e203_exu_alu_share_arb_pkg.sv
// Shared constants for the EXU ALU datapath arbiter: requester indices,
// state encoding and the default lock watchdog limit.
package e203_exu_alu_share_arb_pkg;

    localparam int E203_REQ_ALU    = 0;
    localparam int E203_REQ_BJP    = 1;
    localparam int E203_REQ_AGU    = 2;
    localparam int E203_REQ_MULDIV = 3;

    // Must cover the 33+ cycle iterative divide.
    localparam int E203_LOCK_MAX_CYC = 40;

    typedef enum logic {
        E203_ST_IDLE   = 1'b0,
        E203_ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/e203_exu_alu_share_wdog.sv
// Lock watchdog: saturating count of locked cycles, combinational expiry and a
// registered one-cycle timeout pulse that can be cancelled by flush/normal release.
module e203_exu_alu_share_wdog #(
    parameter int LOCK_MAX_CYC = 40,
    parameter int CNT_W        = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    input  logic cancel,
    output logic expire,
    output logic timeout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX_CYC - 1);

    logic [CNT_W-1:0] cnt;

    assign expire = inc && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= expire & ~cancel;
            if (clr)
                cnt <= '0;
            else if (inc && (cnt != CNT_LAST))
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/e203_exu_alu_share_arb.sv
// Arbiter/sequencer for the shared EXU ALU datapath: fixed-priority grant in
// IDLE, exclusive multi-cycle ownership for AGU/MULDIV, buffer-enable gating.
module e203_exu_alu_share_arb
    import e203_exu_alu_share_arb_pkg::*;
#(
    parameter int LOCK_MAX_CYC = E203_LOCK_MAX_CYC,
    parameter int CNT_W        = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alu_req_valid,
    output logic       alu_req_ready,
    input  logic       bjp_req_valid,
    output logic       bjp_req_ready,
    input  logic       agu_req_valid,
    input  logic       agu_req_lock,
    input  logic       agu_req_last,
    output logic       agu_req_ready,
    input  logic       muldiv_req_valid,
    input  logic       muldiv_req_lock,
    input  logic       muldiv_req_last,
    output logic       muldiv_req_ready,
    input  logic [1:0] agu_sbf_ena_in,
    input  logic [1:0] muldiv_sbf_ena_in,
    output logic       sbf_0_ena,
    output logic       sbf_1_ena,
    output logic       sbf_sel_muldiv,
    output logic [3:0] dpath_sel,
    input  logic       flush_req,
    output logic       dpath_locked,
    output logic       lock_owner,
    output logic       lock_timeout
);

    arb_state_e state, nxt_state;
    logic       nxt_owner;
    logic [3:0] rdy;
    logic [1:0] sbf_ena;
    logic       lock_enter, owner_done, expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= E203_ST_IDLE;
            lock_owner <= 1'b0;
        end else begin
            state      <= nxt_state;
            lock_owner <= nxt_owner;
        end
    end

    always_comb begin
        rdy            = '0;
        sbf_ena        = 2'b00;
        sbf_sel_muldiv = 1'b0;
        nxt_state      = state;
        nxt_owner      = lock_owner;
        lock_enter     = 1'b0;
        owner_done     = 1'b0;
        case (state)
            E203_ST_IDLE: begin
                // Multi-cycle requesters first: their ops were issued earlier and must not stall.
                if (!flush_req) begin
                    if (muldiv_req_valid) begin
                        rdy[E203_REQ_MULDIV] = 1'b1;
                        sbf_ena              = muldiv_sbf_ena_in;
                        sbf_sel_muldiv       = 1'b1;
                        if (muldiv_req_lock && !muldiv_req_last) begin
                            nxt_state  = E203_ST_LOCKED;
                            nxt_owner  = 1'b1;
                            lock_enter = 1'b1;
                        end
                    end else if (agu_req_valid) begin
                        rdy[E203_REQ_AGU] = 1'b1;
                        sbf_ena           = agu_sbf_ena_in;
                        if (agu_req_lock && !agu_req_last) begin
                            nxt_state  = E203_ST_LOCKED;
                            nxt_owner  = 1'b0;
                            lock_enter = 1'b1;
                        end
                    end else if (bjp_req_valid) begin
                        rdy[E203_REQ_BJP] = 1'b1;
                    end else if (alu_req_valid) begin
                        rdy[E203_REQ_ALU] = 1'b1;
                    end
                end
            end
            E203_ST_LOCKED: begin
                sbf_sel_muldiv = lock_owner;
                if (flush_req) begin
                    nxt_state = E203_ST_IDLE;
                end else begin
                    if (lock_owner) begin
                        rdy[E203_REQ_MULDIV] = muldiv_req_valid;
                        sbf_ena              = muldiv_sbf_ena_in;
                        owner_done           = muldiv_req_valid & muldiv_req_last;
                    end else begin
                        rdy[E203_REQ_AGU] = agu_req_valid;
                        sbf_ena           = agu_sbf_ena_in;
                        owner_done        = agu_req_valid & agu_req_last;
                    end
                    if (owner_done || expire)
                        nxt_state = E203_ST_IDLE;
                end
            end
            default: nxt_state = E203_ST_IDLE;
        endcase
    end

    e203_exu_alu_share_wdog #(
        .LOCK_MAX_CYC (LOCK_MAX_CYC),
        .CNT_W        (CNT_W)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (lock_enter | flush_req),
        .inc     (state == E203_ST_LOCKED),
        .cancel  (flush_req | owner_done),
        .expire  (expire),
        .timeout (lock_timeout)
    );

    assign alu_req_ready    = rdy[E203_REQ_ALU];
    assign bjp_req_ready    = rdy[E203_REQ_BJP];
    assign agu_req_ready    = rdy[E203_REQ_AGU];
    assign muldiv_req_ready = rdy[E203_REQ_MULDIV];
    assign dpath_sel        = rdy;
    assign sbf_0_ena        = sbf_ena[0];
    assign sbf_1_ena        = sbf_ena[1];
    assign dpath_locked     = (state == E203_ST_LOCKED);

endmodule

// File: tb/tb_e203_exu_alu_share_arb.sv
// Directed bench for the shared ALU datapath arbiter: grant priority, locks,
// foreign buffer-enable gating, watchdog expiry and flush.
module tb_e203_exu_alu_share_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alu_req_valid, bjp_req_valid;
    logic       agu_req_valid, agu_req_lock, agu_req_last;
    logic       muldiv_req_valid, muldiv_req_lock, muldiv_req_last;
    logic       alu_req_ready, bjp_req_ready, agu_req_ready, muldiv_req_ready;
    logic [1:0] agu_sbf_ena_in, muldiv_sbf_ena_in;
    logic       sbf_0_ena, sbf_1_ena, sbf_sel_muldiv;
    logic [3:0] dpath_sel;
    logic       flush_req, dpath_locked, lock_owner, lock_timeout;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    e203_exu_alu_share_arb #(.LOCK_MAX_CYC(40), .CNT_W(6)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .alu_req_valid     (alu_req_valid),
        .alu_req_ready     (alu_req_ready),
        .bjp_req_valid     (bjp_req_valid),
        .bjp_req_ready     (bjp_req_ready),
        .agu_req_valid     (agu_req_valid),
        .agu_req_lock      (agu_req_lock),
        .agu_req_last      (agu_req_last),
        .agu_req_ready     (agu_req_ready),
        .muldiv_req_valid  (muldiv_req_valid),
        .muldiv_req_lock   (muldiv_req_lock),
        .muldiv_req_last   (muldiv_req_last),
        .muldiv_req_ready  (muldiv_req_ready),
        .agu_sbf_ena_in    (agu_sbf_ena_in),
        .muldiv_sbf_ena_in (muldiv_sbf_ena_in),
        .sbf_0_ena         (sbf_0_ena),
        .sbf_1_ena         (sbf_1_ena),
        .sbf_sel_muldiv    (sbf_sel_muldiv),
        .dpath_sel         (dpath_sel),
        .flush_req         (flush_req),
        .dpath_locked      (dpath_locked),
        .lock_owner        (lock_owner),
        .lock_timeout      (lock_timeout)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_req_valid = 0; bjp_req_valid = 0;
        agu_req_valid = 0; agu_req_lock = 0; agu_req_last = 0;
        muldiv_req_valid = 0; muldiv_req_lock = 0; muldiv_req_last = 0;
        agu_sbf_ena_in = 2'b00; muldiv_sbf_ena_in = 2'b00; flush_req = 0;
    endtask

    function automatic logic [3:0] rdys();
        return {muldiv_req_ready, agu_req_ready, bjp_req_ready, alu_req_ready};
    endfunction

    initial begin
        rst_n = 0;
        idle_inputs();
        #3;
        chk("rst_rdy",     8'(rdys()), 8'h0);
        chk("rst_sel",     8'(dpath_sel), 8'h0);
        chk("rst_locked",  8'(dpath_locked), 8'h0);
        chk("rst_owner",   8'(lock_owner), 8'h0);
        chk("rst_timeout", 8'(lock_timeout), 8'h0);
        chk("rst_sbf",     8'({sbf_1_ena, sbf_0_ena}), 8'h0);
        #4 rst_n = 1;
        tick();

        // ALU alone
        alu_req_valid = 1; #1;
        chk("alu_rdy", 8'(rdys()), 8'b0001);
        chk("alu_sel", 8'(dpath_sel), 8'b0001);
        tick();
        chk("alu_nolock", 8'(dpath_locked), 8'h0);

        // All four valid, MULDIV starts a lock
        bjp_req_valid = 1; agu_req_valid = 1;
        muldiv_req_valid = 1; muldiv_req_lock = 1; muldiv_req_last = 0;
        muldiv_sbf_ena_in = 2'b01; agu_sbf_ena_in = 2'b10; #1;
        chk("prio_rdy", 8'(rdys()), 8'b1000);
        chk("prio_sel", 8'(dpath_sel), 8'b1000);
        chk("prio_sbf", 8'({sbf_1_ena, sbf_0_ena}), 8'b01);
        chk("prio_sbfsel", 8'(sbf_sel_muldiv), 8'h1);
        tick();
        chk("md_locked", 8'(dpath_locked), 8'h1);
        chk("md_owner",  8'(lock_owner), 8'h1);

        // Lock cycles 1..32: foreign requesters toggle and are ignored
        agu_sbf_ena_in = 2'b11;
        for (int i = 1; i <= 32; i++) begin
            alu_req_valid = i[0]; bjp_req_valid = ~i[0]; agu_req_valid = i[1];
            muldiv_sbf_ena_in = i[1:0];
            #1;
            chk("md_lock_rdy", 8'(rdys()), 8'b1000);
            chk("md_lock_sbf", 8'({sbf_1_ena, sbf_0_ena}), 8'(i[1:0]));
            tick();
        end
        // Lock cycle 33: last
        alu_req_valid = 1; muldiv_req_last = 1; muldiv_sbf_ena_in = 2'b00; #1;
        chk("md_last_rdy", 8'(rdys()), 8'b1000);
        chk("md_last_sbfsel", 8'(sbf_sel_muldiv), 8'h1);
        chk("md_last_lock", 8'(dpath_locked), 8'h1);
        tick();
        chk("md_rel_lock", 8'(dpath_locked), 8'h0);
        chk("md_rel_to",   8'(lock_timeout), 8'h0);
        idle_inputs(); alu_req_valid = 1; #1;
        chk("post_md_alu", 8'(rdys()), 8'b0001);
        tick();

        // AGU lock with owner valid dropped for 5 cycles
        idle_inputs();
        agu_req_valid = 1; agu_req_lock = 1; agu_sbf_ena_in = 2'b10; #1;
        chk("agu_grant", 8'(dpath_sel), 8'b0100);
        chk("agu_sbfsel", 8'(sbf_sel_muldiv), 8'h0);
        chk("agu_sbf", 8'({sbf_1_ena, sbf_0_ena}), 8'b10);
        tick();
        chk("agu_owner", 8'({dpath_locked, lock_owner}), 8'b10);
        agu_req_valid = 0; alu_req_valid = 1;
        muldiv_sbf_ena_in = 2'b11; agu_sbf_ena_in = 2'b01;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("agu_gap_sel", 8'(dpath_sel), 8'h0);
            chk("agu_gap_sbf", 8'({sbf_1_ena, sbf_0_ena}), 8'b01);
            tick();
            chk("agu_gap_lock", 8'(dpath_locked), 8'h1);
        end
        agu_req_valid = 1; agu_req_last = 1; #1;
        chk("agu_last_sel", 8'(dpath_sel), 8'b0100);
        tick();
        chk("agu_rel", 8'(dpath_locked), 8'h0);

        // Watchdog: MULDIV never asserts last
        idle_inputs();
        muldiv_req_valid = 1; muldiv_req_lock = 1;
        tick();
        for (int k = 1; k <= 40; k++) begin
            chk("wd_locked", 8'({dpath_locked, lock_timeout}), 8'b10);
            if (k == 40) muldiv_req_valid = 0;
            tick();
        end
        chk("wd_expire", 8'({dpath_locked, lock_timeout}), 8'b01);
        tick();
        chk("wd_pulse_end", 8'(lock_timeout), 8'h0);

        // Flush at AGU lock cycle 10
        idle_inputs();
        agu_req_valid = 1; agu_req_lock = 1;
        tick();
        for (int k = 1; k < 10; k++) tick();
        chk("fl_pre_lock", 8'(dpath_locked), 8'h1);
        flush_req = 1; alu_req_valid = 1; agu_sbf_ena_in = 2'b11; #1;
        chk("fl_rdy", 8'(rdys()), 8'h0);
        chk("fl_sel", 8'(dpath_sel), 8'h0);
        chk("fl_sbf", 8'({sbf_1_ena, sbf_0_ena}), 8'h0);
        tick();
        idle_inputs();
        chk("fl_after", 8'({dpath_locked, lock_timeout}), 8'b00);

        // Flush coincident with watchdog expiry
        muldiv_req_valid = 1; muldiv_req_lock = 1;
        tick();
        for (int k = 1; k < 40; k++) tick();
        chk("flx_pre", 8'({dpath_locked, lock_timeout}), 8'b10);
        flush_req = 1;
        tick();
        idle_inputs();
        chk("flx_after", 8'({dpath_locked, lock_timeout}), 8'b00);
        tick();
        chk("flx_after2", 8'(lock_timeout), 8'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
